// File: rtl/pipelined_adder_sub.sv
// Pipelined adder/subtractor with a valid/ready handshake. Each stage adds one CW-bit chunk
// and hands its carry to the next stage; the last stage also derives overflow and saturates.
module pipelined_adder_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             adv;

  // Per-stage inputs: stage 0 takes the port operands, later stages take the previous registers
  logic             v_src    [STAGES];
  logic [WIDTH-1:0] a_src    [STAGES];
  logic [WIDTH-1:0] bp_src   [STAGES];
  logic [WIDTH-1:0] psum_src [STAGES];
  logic             c_src    [STAGES];
  logic             sat_src  [STAGES];

  logic [WIDTH-1:0] psum_d   [STAGES];
  logic             c_d      [STAGES];

  logic             v_q      [STAGES];
  logic [WIDTH-1:0] a_q      [STAGES];
  logic [WIDTH-1:0] bp_q     [STAGES];
  logic [WIDTH-1:0] psum_q   [STAGES];
  logic             c_q      [STAGES];
  logic             sat_q    [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] res_d;
  logic             ovf_d;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign v_src[gi]    = in_valid;
        assign a_src[gi]    = a;
        assign bp_src[gi]   = sub ? ~b : b;
        assign c_src[gi]    = sub | cin;
        assign sat_src[gi]  = sat;
        assign psum_src[gi] = '0;
      end else begin : g_body
        assign v_src[gi]    = v_q[gi-1];
        assign a_src[gi]    = a_q[gi-1];
        assign bp_src[gi]   = bp_q[gi-1];
        assign c_src[gi]    = c_q[gi-1];
        assign sat_src[gi]  = sat_q[gi-1];
        assign psum_src[gi] = psum_q[gi-1];
      end

      logic [CW:0]      chunk;
      logic [WIDTH-1:0] merged;

      assign chunk = {1'b0, a_src[gi][gi*CW +: CW]}
                   + {1'b0, bp_src[gi][gi*CW +: CW]}
                   + {{CW{1'b0}}, c_src[gi]};

      always_comb begin
        merged                = psum_src[gi];
        merged[gi*CW +: CW]   = chunk[CW-1:0];
      end

      assign psum_d[gi] = merged;
      assign c_d[gi]    = chunk[CW];
    end
  endgenerate

  // Overflow uses the effective B operand, so subtract overflow falls out of the same rule
  assign ovf_d = (a_src[LAST][WIDTH-1] == bp_src[LAST][WIDTH-1]) &&
                 (psum_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

  assign res_d = (sat_src[LAST] && ovf_d)
               ? (a_src[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : psum_d[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= 1'b0;
        a_q[k]    <= '0;
        bp_q[k]   <= '0;
        psum_q[k] <= '0;
        c_q[k]    <= 1'b0;
        sat_q[k]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]    <= v_src[k];
        a_q[k]    <= a_src[k];
        bp_q[k]   <= bp_src[k];
        psum_q[k] <= (k == LAST) ? res_d : psum_d[k];
        c_q[k]    <= c_d[k];
        sat_q[k]  <= sat_src[k];
      end
      ovf_q <= ovf_d;
    end
  end

  // Whole pipeline moves in lockstep; a stalled output freezes every stage
  assign adv       = !v_q[LAST] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = psum_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Randomised and directed bench for pipelined_adder_sub against a word-level arithmetic model.
module tb_pipelined_adder_sub;

  localparam int STAGES = 4;

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          age;
  } ent_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, cin, sub, sat, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic       v8;
  logic [7:0] a8s, b8s, a8p, b8p, s1, s8;
  logic       r1, ov1, c1, o1, r8, ov8, c8, o8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0, mark = 0, mode = 0;
  int   emitted = 0;
  bit   last_acc = 0, collect = 0, saw_low = 0, prev_stall = 0;
  logic [31:0] prev_sum;
  logic [31:0] got_q[$];
  ent_t exp_q[$];

  pipelined_adder_sub #(.WIDTH(32), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r1),
    .a(a8s), .b(b8s), .cin(1'b0), .sub(1'b0), .sat(1'b0),
    .out_valid(ov1), .out_ready(1'b1), .sum(s1), .cout(c1), .ovf(o1)
  );

  pipelined_adder_sub #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .a(a8p), .b(b8p), .cin(1'b0), .sub(1'b0), .sat(1'b0),
    .out_valid(ov8), .out_ready(1'b1), .sum(s8), .cout(c8), .ovf(o8)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Word-level reference: plain 33-bit arithmetic on the whole operands
  function automatic ent_t model(input logic [31:0] aa, input logic [31:0] bb,
                                 input logic s, input logic c, input logic st);
    logic [32:0] full;
    logic [31:0] bp;
    ent_t e;
    bp    = s ? ~bb : bb;
    full  = {1'b0, aa} + {1'b0, bp} + {32'd0, (s ? 1'b1 : c)};
    e.c   = full[32];
    e.o   = (aa[31] == bp[31]) && (full[31] != aa[31]);
    e.s   = (st && e.o) ? (aa[31] ? 32'h8000_0000 : 32'h7fff_ffff) : full[31:0];
    e.age = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7fff_ffff;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'h0;
      default: return $urandom();
    endcase
  endfunction

  // Consumer side: out_ready pattern selected by mode
  always @(posedge clk) begin
    #2;
    cyc++;
    case (mode)
      1: out_ready = !((cyc - mark) >= 3 && (cyc - mark) <= 6);
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Compare process: checks every cycle, then advances the model for the coming edge
  always @(negedge clk) begin
    ent_t e;
    bit   exp_v, adv_m;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
      last_acc   = 0;
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].age >= STAGES);
      adv_m = !exp_v || out_ready;
      chk("in_ready", {63'd0, in_ready}, {63'd0, adv_m});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      if (exp_v) begin
        chk("sum", {32'd0, sum}, {32'd0, exp_q[0].s});
        chk("cout", {63'd0, cout}, {63'd0, exp_q[0].c});
        chk("ovf", {63'd0, ovf}, {63'd0, exp_q[0].o});
      end
      if (prev_stall)
        chk("hold_sum", {32'd0, sum}, {32'd0, prev_sum});
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      if (collect && !in_ready) saw_low = 1;
      if (out_valid && out_ready) begin
        emitted++;
        if (collect) got_q.push_back(sum);
        $display("emit %0d: sum=%h cout=%b ovf=%b", emitted, sum, cout, ovf);
      end
      if (adv_m) begin
        if (exp_v) void'(exp_q.pop_front());
        foreach (exp_q[i]) exp_q[i].age++;
        if (in_valid) begin
          e = model(a, b, sub, cin, sat);
          e.age = 1;
          exp_q.push_back(e);
        end
      end
      last_acc = in_valid && adv_m;
    end
  end

  task automatic send(input logic [31:0] aa, input logic [31:0] bb,
                      input logic s, input logic c, input logic st);
    int n = 0;
    in_valid = 1; a = aa; b = bb; sub = s; cin = c; sat = st;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    ent_t m;
    int   n, lat1, lat8;
    logic [7:0] r1s, r8s;
    logic       r8c, r1o;

    rst_n = 1; in_valid = 0; a = 0; b = 0; sub = 0; cin = 0; sat = 0; out_ready = 1;
    v8 = 0; a8s = 0; b8s = 0; a8p = 0; b8p = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);

    // Pin the reference model to hand-computed results
    m = model(32'h7fff_ffff, 32'h1, 0, 0, 0);
    chk("model_ovf_add", {31'd0, m.s, m.o, m.c}, {31'd0, 32'h8000_0000, 1'b1, 1'b0});
    m = model(32'h7fff_ffff, 32'h1, 0, 0, 1);
    chk("model_sat_pos", {32'd0, m.s}, {32'd0, 32'h7fff_ffff});
    m = model(32'hffff_ffff, 32'h8000_0000, 0, 0, 0);
    chk("model_neg_ovf", {31'd0, m.s, m.o, m.c}, {31'd0, 32'h7fff_ffff, 1'b1, 1'b1});
    m = model(32'hffff_ffff, 32'h8000_0000, 0, 0, 1);
    chk("model_sat_neg", {32'd0, m.s}, {32'd0, 32'h8000_0000});
    m = model(32'h2, 32'h5, 1, 0, 0);
    chk("model_sub", {31'd0, m.s, m.o, m.c}, {31'd0, 32'hffff_fffd, 1'b0, 1'b0});
    m = model(32'hc, 32'h19, 0, 1, 0);
    chk("model_cin", {31'd0, m.s, m.o, m.c}, {31'd0, 32'h26, 1'b0, 1'b0});

    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    #1;
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed beats from the plan, checked by the scoreboard
    send(32'h7fff_ffff, 32'h1, 0, 0, 0);
    send(32'h7fff_ffff, 32'h1, 0, 0, 1);
    send(32'hffff_ffff, 32'h8000_0000, 0, 0, 0);
    send(32'hffff_ffff, 32'h8000_0000, 0, 0, 1);
    send(32'h2, 32'h5, 1, 0, 0);
    send(32'h2, 32'h5, 1, 1, 0);
    send(32'hc, 32'h19, 0, 1, 0);
    drain();

    // Stream of 8 beats with a consumer stall
    got_q.delete();
    saw_low = 0;
    collect = 1;
    mark = cyc;
    mode = 1;
    for (int i = 1; i <= 8; i++) send(i, 2 * i, 0, 0, 0);
    drain();
    collect = 0;
    mode = 0;
    chk("stall_ready_low", {63'd0, saw_low}, 64'd1);
    chk("stall_count", got_q.size(), 64'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      chk("stall_order", {32'd0, got_q[i]}, 3 * (i + 1));

    // Reset with three beats in flight
    @(posedge clk); #1;
    send(32'h100, 32'h1, 0, 0, 0);
    send(32'h200, 32'h2, 0, 0, 0);
    send(32'h300, 32'h3, 0, 0, 0);
    #1 rst_n = 0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_sum", {32'd0, sum}, 64'd0);
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    emitted = 0;
    send(32'h0, 32'ha, 0, 0, 0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("post_rst_latency", n, STAGES);
    chk("post_rst_sum", {32'd0, sum}, 64'ha);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_stale", emitted, 64'd1);

    // Narrow configurations: single stage and one bit per stage
    @(posedge clk); #1;
    a8s = 8'h7f; b8s = 8'h01; a8p = 8'hff; b8p = 8'h01; v8 = 1;
    @(posedge clk); #1;
    v8 = 0;
    lat1 = 0; lat8 = 0; r1s = 0; r8s = 8'hee; r8c = 0; r1o = 0;
    for (int k = 1; k <= 12; k++) begin
      if (ov1 && lat1 == 0) begin lat1 = k; r1s = s1; r1o = o1; end
      if (ov8 && lat8 == 0) begin lat8 = k; r8s = s8; r8c = c8; end
      @(posedge clk); #1;
    end
    $display("w8 s1: sum=%h ovf=%b lat=%0d; s8: sum=%h cout=%b lat=%0d", r1s, r1o, lat1, r8s, r8c, lat8);
    chk("s1_latency", lat1, 64'd1);
    chk("s1_sum", {56'd0, r1s}, 64'h80);
    chk("s1_ovf", {63'd0, r1o}, 64'd1);
    chk("s8_latency", lat8, 64'd8);
    chk("s8_sum", {56'd0, r8s}, 64'h00);
    chk("s8_cout", {63'd0, r8c}, 64'd1);

    // Randomised traffic with random backpressure and input bubbles
    mode = 2;
    for (int i = 0; i < 300; i++) begin
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    mode = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
